// File: rtl/linear_mix_pkg.sv
// ----------------------------------------------------------------------------
// linear_mix_pkg
//  Shared types and constants for the Serpent linear-transform engine.
//  Contents:
//   WORD_W / BLOCK_W     word and block widths
//   ROT_* / SHL_*        rotation and shift amounts of one linear-transform pass
//   state_t              engine FSM states (IDLE, RUN, DONE)
//   rotl / rotr          32-bit rotate helpers
//  No ports (package).
// ----------------------------------------------------------------------------
package linear_mix_pkg;

   localparam int WORD_W  = 32;
   localparam int BLOCK_W = 128;

   // Rotation amounts in the order they appear in the forward pass.
   localparam int ROT_A1 = 13;
   localparam int ROT_C1 = 3;
   localparam int ROT_B  = 1;
   localparam int ROT_D  = 7;
   localparam int ROT_A2 = 5;
   localparam int ROT_C2 = 22;

   // Plain left shifts (upper bits are discarded).
   localparam int SHL_A = 3;
   localparam int SHL_B = 7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Callers only use nonzero amounts, so the complementary shift never
   // reaches WORD_W.
   function automatic logic [WORD_W-1:0] rotl(input logic [WORD_W-1:0] x,
                                              input int unsigned s);
      return (x << s) | (x >> (WORD_W - s));
   endfunction

   function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x,
                                              input int unsigned s);
      return (x >> s) | (x << (WORD_W - s));
   endfunction

endpackage

// File: rtl/linear_mix_pass.sv
// ----------------------------------------------------------------------------
// linear_mix_pass
//  Combinational single pass of the Serpent linear transform.
//  Optional feature macro: LINEAR_MIX_KEYXOR_EN
//   When defined, a 128-bit key {A,B,C,D} is XORed into the words before a
//   forward pass or after an inverse pass.
//  Ports:
//   key          in  128  pass key {A,B,C,D} (only with LINEAR_MIX_KEYXOR_EN)
//   in_a..in_d   in  32   words entering the pass
//   dir          in  1    0 = forward transform, 1 = inverse transform
//   out_a..out_d out 32   words leaving the pass
// ----------------------------------------------------------------------------
module linear_mix_pass
   import linear_mix_pkg::*;
(
`ifdef LINEAR_MIX_KEYXOR_EN
   input  logic [BLOCK_W-1:0] key,
`endif
   input  logic [WORD_W-1:0]  in_a,
   input  logic [WORD_W-1:0]  in_b,
   input  logic [WORD_W-1:0]  in_c,
   input  logic [WORD_W-1:0]  in_d,
   input  logic               dir,
   output logic [WORD_W-1:0]  out_a,
   output logic [WORD_W-1:0]  out_b,
   output logic [WORD_W-1:0]  out_c,
   output logic [WORD_W-1:0]  out_d
);

   logic [WORD_W-1:0] ka, kb, kc, kd;
   logic [WORD_W-1:0] a, b, c, d;

`ifdef LINEAR_MIX_KEYXOR_EN
   assign {ka, kb, kc, kd} = key;
`else
   // Without the key feature the pass is the pure transform (key of zero).
   assign {ka, kb, kc, kd} = '0;
`endif

   // NOTE: blocking assignments here are intentional -- each step consumes
   //       the value produced by the previous step, like the reference
   //       algorithm; every variable is written at the top of both branches,
   //       so no latch can be inferred.
   always_comb begin
      if (!dir) begin
         a = in_a ^ ka;
         b = in_b ^ kb;
         c = in_c ^ kc;
         d = in_d ^ kd;
         a = rotl(a, ROT_A1);
         c = rotl(c, ROT_C1);
         b = b ^ a ^ c;
         d = d ^ c ^ (a << SHL_A);
         b = rotl(b, ROT_B);
         d = rotl(d, ROT_D);
         a = a ^ b ^ d;
         c = c ^ d ^ (b << SHL_B);
         a = rotl(a, ROT_A2);
         c = rotl(c, ROT_C2);
      end else begin
         a = in_a;
         b = in_b;
         c = in_c;
         d = in_d;
         c = rotr(c, ROT_C2);
         a = rotr(a, ROT_A2);
         c = c ^ d ^ (b << SHL_B);
         a = a ^ b ^ d;
         d = rotr(d, ROT_D);
         b = rotr(b, ROT_B);
         d = d ^ c ^ (a << SHL_A);
         b = b ^ a ^ c;
         c = rotr(c, ROT_C1);
         a = rotr(a, ROT_A1);
         a = a ^ ka;
         b = b ^ kb;
         c = c ^ kc;
         d = d ^ kd;
      end
   end

   assign out_a = a;
   assign out_b = b;
   assign out_c = c;
   assign out_d = d;

endmodule

// File: rtl/linear_mix_engine.sv
// ----------------------------------------------------------------------------
// linear_mix_engine
//  Iterative, valid/ready handshaked Serpent linear-transform engine. A block
//  is accepted in IDLE, then min(pass_count, MAX_PASSES) forward or inverse
//  passes are applied, one per clock, and the result is held in DONE until
//  the consumer takes it. Exactly one block is in flight at a time.
//  Optional feature macro: LINEAR_MIX_KEYXOR_EN (adds key_in, latched at
//  accept and mixed into every pass).
//  Ports:
//   clk          in   1       rising-edge clock
//   rst          in   1       synchronous active-high reset
//   in_valid     in   1       input block valid
//   in_ready     out  1       engine can accept a block (IDLE and not in reset)
//   in_a..in_d   in   32 ea   input words A..D
//   dir          in   1       0 = forward, 1 = inverse; sampled at accept
//   pass_count   in   PASS_W  passes to apply; sampled at accept
//   key_in       in   128     per-pass key (only with LINEAR_MIX_KEYXOR_EN)
//   out_valid    out  1       result valid, held until consumed
//   out_ready    in   1       consumer takes the result
//   out_a..out_d out  32 ea   result words
// ----------------------------------------------------------------------------
module linear_mix_engine
   import linear_mix_pkg::*;
#(
   parameter int MAX_PASSES = 32,
   parameter int PASS_W     = $clog2(MAX_PASSES + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WORD_W-1:0]  in_a,
   input  logic [WORD_W-1:0]  in_b,
   input  logic [WORD_W-1:0]  in_c,
   input  logic [WORD_W-1:0]  in_d,
   input  logic               dir,
   input  logic [PASS_W-1:0]  pass_count,
`ifdef LINEAR_MIX_KEYXOR_EN
   input  logic [BLOCK_W-1:0] key_in,
`endif
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WORD_W-1:0]  out_a,
   output logic [WORD_W-1:0]  out_b,
   output logic [WORD_W-1:0]  out_c,
   output logic [WORD_W-1:0]  out_d
);

   state_t            state;
   logic [PASS_W-1:0] cnt;
   logic              dir_q;
   logic [PASS_W-1:0] n_req;
   logic              accept;
   logic [WORD_W-1:0] p_a, p_b, p_c, p_d;

`ifdef LINEAR_MIX_KEYXOR_EN
   logic [BLOCK_W-1:0] key_q;
`endif

   // Requests beyond MAX_PASSES are clamped rather than wrapped.
   assign n_req = (pass_count > PASS_W'(MAX_PASSES)) ? PASS_W'(MAX_PASSES)
                                                     : pass_count;

   assign in_ready = (state == IDLE) && !rst;
   assign accept   = in_valid && in_ready;

   // out_a..out_d double as the working registers: the pass unit iterates
   // on them during RUN and they freeze once DONE is reached.
   linear_mix_pass u_pass (
`ifdef LINEAR_MIX_KEYXOR_EN
      .key   (key_q),
`endif
      .in_a  (out_a),
      .in_b  (out_b),
      .in_c  (out_c),
      .in_d  (out_d),
      .dir   (dir_q),
      .out_a (p_a),
      .out_b (p_b),
      .out_c (p_c),
      .out_d (p_d)
   );

   // NOTE: sequential state is written with non-blocking assignments only,
   //       so every register samples pre-edge values regardless of order.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the datapath registers are reset too, because they are the
         //       visible outputs and must read zero after reset.
         state     <= IDLE;
         out_valid <= 1'b0;
         out_a     <= '0;
         out_b     <= '0;
         out_c     <= '0;
         out_d     <= '0;
         cnt       <= '0;
         dir_q     <= 1'b0;
`ifdef LINEAR_MIX_KEYXOR_EN
         key_q     <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  out_a <= in_a;
                  out_b <= in_b;
                  out_c <= in_c;
                  out_d <= in_d;
                  dir_q <= dir;
`ifdef LINEAR_MIX_KEYXOR_EN
                  key_q <= key_in;
`endif
                  cnt   <= n_req;
                  state <= (n_req == '0) ? DONE : RUN;
               end
            end
            RUN: begin
               out_a <= p_a;
               out_b <= p_b;
               out_c <= p_c;
               out_d <= p_d;
               cnt   <= cnt - 1'b1;
               if (cnt == PASS_W'(1)) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
               end
            end
            DONE: begin
               // A zero-pass block enters DONE with out_valid low so that
               // the result still appears one cycle after accept.
               if (!out_valid) begin
                  out_valid <= 1'b1;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
